// File: rtl/ctrl_types_pkg.sv
// ============================================================================
// Module      : ctrl_types_pkg
// Description : Shared state, opcode and status types for the cache controller.
// Revision    : 1.1 - adds response state, status codes and sub-states
// ============================================================================
`default_nettype none

package ctrl_types_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET    = 3'd1,
        ST_UPSERT = 3'd2,
        ST_DEL    = 3'd3,
        ST_ERR    = 3'd4,
        ST_RESP   = 3'd5
    } top_state_e;

    typedef enum logic [2:0] {
        OP_NOOP   = 3'd0,
        OP_GET    = 3'd1,
        OP_UPSERT = 3'd2,
        OP_DELETE = 3'd3
    } operation_e;

    typedef enum logic [1:0] {
        STATUS_OK        = 2'd0,
        STATUS_NOT_FOUND = 2'd1,
        STATUS_FULL      = 2'd2,
        STATUS_BAD_OP    = 2'd3
    } status_e;

    typedef enum logic [0:0] {GET_ST_START = 1'b0, GET_ST_READ = 1'b1} get_substate_e;
    typedef enum logic [0:0] {UPSERT_ST_START = 1'b0} put_substate_e;
    typedef enum logic [0:0] {DEL_ST_START = 1'b0} del_substate_e;

    typedef struct packed {
        get_substate_e get_sub;
        put_substate_e put_sub;
        del_substate_e del_sub;
    } sub_cmd_t;

    localparam sub_cmd_t c_sub_start = '{
        get_sub: GET_ST_START,
        put_sub: UPSERT_ST_START,
        del_sub: DEL_ST_START
    };

endpackage

`default_nettype wire

// File: rtl/onehot_prio_enc.sv
// ============================================================================
// Module      : onehot_prio_enc
// Description : Isolates the lowest set bit of a vector; flags any bit set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0] vec_i,
    output logic [N-1:0] onehot_o,
    output logic         any_o
);

    // Two's complement negation keeps only the lowest set bit after the AND.
    assign onehot_o = vec_i & (-vec_i);
    assign any_o    = |vec_i;

endmodule

`default_nettype wire

// File: rtl/cache_op_ctrl.sv
// ============================================================================
// Module      : cache_op_ctrl
// Description : Sequences GET/UPSERT/DELETE/NOOP requests against the entry array.
// Revision    : 2.0 - parametrised widths, full-array and bad-opcode handling
// ============================================================================
`default_nettype none

module cache_op_ctrl
    import ctrl_types_pkg::*;
#(
    parameter int KEY_W       = 32,
    parameter int VAL_W       = 64,
    parameter int NUM_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [2:0]             req_op_i,
    input  logic [KEY_W-1:0]       req_key_i,
    input  logic [VAL_W-1:0]       req_value_i,
    output logic [KEY_W-1:0]       mem_key_o,
    output logic [VAL_W-1:0]       mem_value_o,
    input  logic [NUM_ENTRIES-1:0] mem_hit_i,
    input  logic [NUM_ENTRIES-1:0] mem_used_i,
    output logic [NUM_ENTRIES-1:0] mem_sel_o,
    output logic                   mem_we_o,
    output logic                   mem_clr_o,
    input  logic [VAL_W-1:0]       mem_rd_data_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [1:0]             resp_status_o,
    output logic [VAL_W-1:0]       resp_value_o,
    output logic [CNT_W-1:0]       err_count_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    top_state_e             state_q;
    sub_cmd_t               sub_q;
    logic                   req_ready_q;
    logic [KEY_W-1:0]       key_q;
    logic [VAL_W-1:0]       value_q;
    logic                   resp_valid_q;
    status_e                resp_status_q;
    logic [VAL_W-1:0]       resp_value_q;
    logic [CNT_W-1:0]       err_count_q;
    logic [CNT_W-1:0]       err_count_d;

    logic [NUM_ENTRIES-1:0] hit_oh;
    logic [NUM_ENTRIES-1:0] free_oh;
    logic                   hit_any;
    logic                   free_any;

    onehot_prio_enc #(.N(NUM_ENTRIES)) u_hit_enc (
        .vec_i    (mem_hit_i),
        .onehot_o (hit_oh),
        .any_o    (hit_any)
    );

    onehot_prio_enc #(.N(NUM_ENTRIES)) u_free_enc (
        .vec_i    (~mem_used_i),
        .onehot_o (free_oh),
        .any_o    (free_any)
    );

    // Array select and strobes follow the live hit vector during the lookup cycle only.
    always_comb begin
        mem_sel_o = '0;
        mem_we_o  = 1'b0;
        mem_clr_o = 1'b0;
        case (state_q)
            ST_GET: begin
                if (sub_q.get_sub == GET_ST_START) mem_sel_o = hit_oh;
            end
            ST_UPSERT: begin
                if (sub_q.put_sub == UPSERT_ST_START) begin
                    mem_sel_o = hit_any ? hit_oh : free_oh;
                    mem_we_o  = hit_any | free_any;
                end
            end
            ST_DEL: begin
                if (sub_q.del_sub == DEL_ST_START) begin
                    mem_sel_o = hit_oh;
                    mem_clr_o = hit_any;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        err_count_d = err_count_q;
        if (resp_valid_q && resp_ready_i && (resp_status_q != STATUS_OK) &&
            (err_count_q != c_cnt_max)) begin
            err_count_d = err_count_q + c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sub_q         <= c_sub_start;
            req_ready_q   <= 1'b0;
            key_q         <= '0;
            value_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= STATUS_OK;
            resp_value_q  <= '0;
            err_count_q   <= '0;
        end else begin
            err_count_q <= err_count_d;
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_ready_q && req_valid_i) begin
                        req_ready_q  <= 1'b0;
                        key_q        <= req_key_i;
                        value_q      <= req_value_i;
                        sub_q        <= c_sub_start;
                        resp_value_q <= '0;
                        case (req_op_i)
                            OP_NOOP: begin
                                resp_status_q <= STATUS_OK;
                                resp_valid_q  <= 1'b1;
                                state_q       <= ST_RESP;
                            end
                            OP_GET:    state_q <= ST_GET;
                            OP_UPSERT: state_q <= ST_UPSERT;
                            OP_DELETE: state_q <= ST_DEL;
                            default: begin
                                resp_status_q <= STATUS_BAD_OP;
                                resp_valid_q  <= 1'b1;
                                state_q       <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_GET: begin
                    if (sub_q.get_sub == GET_ST_START) begin
                        if (hit_any) begin
                            sub_q.get_sub <= GET_ST_READ;
                        end else begin
                            resp_status_q <= STATUS_NOT_FOUND;
                            resp_valid_q  <= 1'b1;
                            state_q       <= ST_RESP;
                        end
                    end else begin
                        resp_value_q  <= mem_rd_data_i;
                        resp_status_q <= STATUS_OK;
                        resp_valid_q  <= 1'b1;
                        state_q       <= ST_RESP;
                    end
                end
                ST_UPSERT: begin
                    resp_status_q <= (hit_any || free_any) ? STATUS_OK : STATUS_FULL;
                    resp_valid_q  <= 1'b1;
                    state_q       <= ST_RESP;
                end
                ST_DEL: begin
                    resp_status_q <= hit_any ? STATUS_OK : STATUS_NOT_FOUND;
                    resp_valid_q  <= 1'b1;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign mem_key_o     = key_q;
    assign mem_value_o   = value_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_status_o = resp_status_q;
    assign resp_value_o  = resp_value_q;
    assign err_count_o   = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_op_ctrl.sv
// ============================================================================
// Module      : tb_cache_op_ctrl
// Description : Directed self-checking bench for cache_op_ctrl with cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_op_ctrl;

    localparam int KEY_W = 32;
    localparam int VAL_W = 64;
    localparam int NE    = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid_i = 1'b0;
    logic [2:0]       req_op_i = '0;
    logic [KEY_W-1:0] req_key_i = '0;
    logic [VAL_W-1:0] req_value_i = '0;
    logic [NE-1:0]    mem_hit_i = '0;
    logic [NE-1:0]    mem_used_i = '0;
    logic [VAL_W-1:0] mem_rd_data_i = '0;
    logic             resp_ready_i = 1'b0;

    logic             req_ready_o, mem_we_o, mem_clr_o, resp_valid_o;
    logic [KEY_W-1:0] mem_key_o;
    logic [VAL_W-1:0] mem_value_o, resp_value_o;
    logic [NE-1:0]    mem_sel_o;
    logic [1:0]       resp_status_o;
    logic [CNT_W-1:0] err_count_o;

    logic             d2_req_ready, d2_we, d2_clr, d2_resp_valid;
    logic [KEY_W-1:0] d2_key;
    logic [VAL_W-1:0] d2_value, d2_resp_value;
    logic [NE-1:0]    d2_sel;
    logic [1:0]       d2_status;
    logic [1:0]       d2_err;

    cache_op_ctrl #(.KEY_W(KEY_W), .VAL_W(VAL_W), .NUM_ENTRIES(NE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_key_i(req_key_i), .req_value_i(req_value_i),
        .mem_key_o(mem_key_o), .mem_value_o(mem_value_o),
        .mem_hit_i(mem_hit_i), .mem_used_i(mem_used_i), .mem_sel_o(mem_sel_o),
        .mem_we_o(mem_we_o), .mem_clr_o(mem_clr_o), .mem_rd_data_i(mem_rd_data_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_status_o(resp_status_o), .resp_value_o(resp_value_o),
        .err_count_o(err_count_o)
    );

    cache_op_ctrl #(.KEY_W(KEY_W), .VAL_W(VAL_W), .NUM_ENTRIES(NE), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(d2_req_ready), .req_op_i(req_op_i),
        .req_key_i(req_key_i), .req_value_i(req_value_i),
        .mem_key_o(d2_key), .mem_value_o(d2_value),
        .mem_hit_i(mem_hit_i), .mem_used_i(mem_used_i), .mem_sel_o(d2_sel),
        .mem_we_o(d2_we), .mem_clr_o(d2_clr), .mem_rd_data_i(mem_rd_data_i),
        .resp_valid_o(d2_resp_valid), .resp_ready_i(resp_ready_i),
        .resp_status_o(d2_status), .resp_value_o(d2_resp_value),
        .err_count_o(d2_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic             chk_en = 1'b0;
    logic             exp_ready = 1'b0, exp_we = 1'b0, exp_clr = 1'b0, exp_rvalid = 1'b0;
    logic [NE-1:0]    exp_sel = '0;
    logic [1:0]       exp_status = '0;
    logic [VAL_W-1:0] exp_value = '0, exp_val = '0;
    logic [KEY_W-1:0] exp_key = '0;
    int               model_err = 0;

    logic [NE-1:0]    seen_sel = '0;
    logic [1:0]       seen_status = '0;
    logic [VAL_W-1:0] seen_value = '0;
    int               we_cyc = 0, clr_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic logic [NE-1:0] lowest(input logic [NE-1:0] v);
        for (int i = 0; i < NE; i++) if (v[i]) return NE'(1) << i;
        return '0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
            chk("mem_sel", 64'(mem_sel_o), 64'(exp_sel));
            chk("mem_we", 64'(mem_we_o), 64'(exp_we));
            chk("mem_clr", 64'(mem_clr_o), 64'(exp_clr));
            chk("mem_key", 64'(mem_key_o), 64'(exp_key));
            chk("mem_value", mem_value_o, exp_val);
            chk("resp_valid", 64'(resp_valid_o), 64'(exp_rvalid));
            if (exp_rvalid) begin
                chk("resp_status", 64'(resp_status_o), 64'(exp_status));
                chk("resp_value", resp_value_o, exp_value);
            end
            chk("err_count", 64'(err_count_o), 64'(model_err));
            chk("err_count_w2", 64'(d2_err), 64'((model_err > 3) ? 3 : model_err));
            if (mem_sel_o != '0) seen_sel = mem_sel_o;
            if (mem_we_o) we_cyc++;
            if (mem_clr_o) clr_cyc++;
            if (resp_valid_o) begin
                seen_status = resp_status_o;
                seen_value  = resp_value_o;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_ready = 1'b1; exp_sel = '0; exp_we = 1'b0; exp_clr = 1'b0; exp_rvalid = 1'b0;
    endtask

    // One full transaction; expectations come from the operation rules, not the RTL.
    task automatic run_op(input logic [2:0] op, input logic [KEY_W-1:0] key,
                          input logic [VAL_W-1:0] val, input logic [NE-1:0] hit,
                          input logic [NE-1:0] used, input logic [VAL_W-1:0] rd,
                          input int hold);
        int               lat;
        logic [NE-1:0]    e_sel;
        logic             e_we, e_clr;
        logic [1:0]       e_st;
        logic [VAL_W-1:0] e_val;
        e_sel = '0; e_we = 1'b0; e_clr = 1'b0; e_st = 2'd0; e_val = '0;
        case (op)
            3'd0: lat = 1;
            3'd1: begin
                lat = (hit != '0) ? 3 : 2;
                e_sel = lowest(hit);
                e_st  = (hit != '0) ? 2'd0 : 2'd1;
                e_val = (hit != '0) ? rd : '0;
            end
            3'd2: begin
                lat = 2;
                if (hit != '0) begin
                    e_sel = lowest(hit); e_we = 1'b1;
                end else if (~used != '0) begin
                    e_sel = lowest(~used); e_we = 1'b1;
                end else begin
                    e_st = 2'd2;
                end
            end
            3'd3: begin
                lat = 2;
                e_sel = lowest(hit);
                e_clr = (hit != '0);
                e_st  = (hit != '0) ? 2'd0 : 2'd1;
            end
            default: begin
                lat = 1;
                e_st = 2'd3;
            end
        endcase

        seen_sel = '0; we_cyc = 0; clr_cyc = 0;
        req_valid_i = 1'b1; req_op_i = op; req_key_i = key; req_value_i = val;
        mem_hit_i = hit; mem_used_i = used; mem_rd_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
        resp_ready_i = 1'b0;
        idle_exp();
        step();
        req_valid_i = 1'b0; req_key_i = ~key; req_value_i = ~val;
        exp_key = key; exp_val = val; exp_ready = 1'b0;
        for (int c = 1; c < lat; c++) begin
            mem_rd_data_i = (c == 2) ? rd : 64'hDEAD_DEAD_DEAD_DEAD;
            exp_sel = (c == 1) ? e_sel : '0;
            exp_we  = (c == 1) && e_we;
            exp_clr = (c == 1) && e_clr;
            step();
        end
        mem_rd_data_i = 64'hDEAD_DEAD_DEAD_DEAD;
        exp_sel = '0; exp_we = 1'b0; exp_clr = 1'b0;
        exp_rvalid = 1'b1; exp_status = e_st; exp_value = e_val;
        for (int h = 0; h <= hold; h++) begin
            resp_ready_i = (h == hold);
            step();
        end
        resp_ready_i = 1'b0;
        if (e_st != 2'd0) model_err++;
        idle_exp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        idle_exp();
        step();

        run_op(3'd2, 32'h0000_00AA, 64'h1234, 16'h0000, 16'h0000, 64'h0, 0);
        chk("lit_upsert_sel", 64'(seen_sel), 64'h0001);
        chk("lit_upsert_we_cycles", 64'(we_cyc), 64'd1);
        chk("lit_upsert_err", 64'(err_count_o), 64'd0);

        run_op(3'd1, 32'h0000_00AA, 64'h0, 16'h0004, 16'h0001, 64'hBEEF, 1);
        chk("lit_get_sel", 64'(seen_sel), 64'h0004);
        chk("lit_get_value", seen_value, 64'hBEEF);

        run_op(3'd2, 32'h0000_00BB, 64'h77, 16'h0000, 16'hFFFF, 64'h0, 0);
        chk("lit_full_status", 64'(seen_status), 64'd2);
        chk("lit_full_we_cycles", 64'(we_cyc), 64'd0);
        chk("lit_full_err", 64'(err_count_o), 64'd1);

        run_op(3'd3, 32'h0000_00CC, 64'h0, 16'h0000, 16'hFFFF, 64'h0, 0);
        chk("lit_delmiss_err", 64'(err_count_o), 64'd2);

        run_op(3'b101, 32'h0000_0001, 64'h5, 16'h0001, 16'h0001, 64'h0, 5);
        chk("lit_badop_status", 64'(seen_status), 64'd3);

        run_op(3'd3, 32'h0000_00DD, 64'h0, 16'h0030, 16'h0030, 64'h0, 0);
        chk("lit_del_sel", 64'(seen_sel), 64'h0010);
        chk("lit_del_clr_cycles", 64'(clr_cyc), 64'd1);

        run_op(3'd1, 32'h0000_00EE, 64'h0, 16'h0000, 16'h00FF, 64'h1111, 2);
        run_op(3'b111, 32'h0000_00EF, 64'h0, 16'h0000, 16'h0000, 64'h0, 0);
        chk("lit_sat_w2", 64'(d2_err), 64'd3);
        chk("lit_err_5", 64'(err_count_o), 64'd5);

        run_op(3'd2, 32'h1234_5678, 64'hCAFE, 16'h0100, 16'hFFFF, 64'h0, 0);
        chk("lit_overwrite_sel", 64'(seen_sel), 64'h0100);
        run_op(3'd2, 32'h1234_5679, 64'hF00D, 16'h0000, 16'h00FF, 64'h0, 1);
        chk("lit_free_sel", 64'(seen_sel), 64'h0100);
        run_op(3'd0, 32'h0, 64'h0, 16'h0000, 16'h0000, 64'h0, 0);
        chk("lit_noop_status", 64'(seen_status), 64'd0);

        // Reset asserted while the GET is in its read cycle.
        req_valid_i = 1'b1; req_op_i = 3'd1; req_key_i = 32'h55; req_value_i = 64'h99;
        mem_hit_i = 16'h0008; mem_used_i = 16'h00FF; resp_ready_i = 1'b1;
        idle_exp();
        step();
        req_valid_i = 1'b0;
        exp_key = 32'h55; exp_val = 64'h99; exp_ready = 1'b0; exp_sel = 16'h0008;
        step();
        rst_n = 1'b0; exp_sel = '0; mem_rd_data_i = 64'hABCD;
        step();
        rst_n = 1'b1; exp_key = '0; exp_val = '0; model_err = 0;
        step();
        idle_exp();
        step();
        step();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
